// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder serving one load/store per handshake
// from an internal 64-bit word array, with a one-cycle response pulse and error flag.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    addr_q, wdata_q, rdata_q;
  logic           wr_q, err_q;
  logic [63:0]    mem [DEPTH_WORDS];
  logic           accept, commit, c_wr, c_err;
  logic [63:0]    c_addr, c_wdata;
  logic [AW-1:0]  c_idx;
  // With LATENCY=1 the commit edge is the acceptance edge, so use the live request
  always_comb begin
    accept  = state_q == IDLE && req_valid;
    commit  = (accept && LATENCY == 1) || (state_q == BUSY && cnt_q == '0);
    c_addr  = state_q == IDLE ? req_addr : addr_q;
    c_wr    = state_q == IDLE ? req_wr : wr_q;
    c_wdata = state_q == IDLE ? req_wdata : wdata_q;
    c_idx   = c_addr[AW+2:3];
    c_err   = c_addr[2:0] != 3'd0 || c_addr[63:3] >= 61'(DEPTH_WORDS);
    state_d = accept ? (LATENCY == 1 ? RESP : BUSY)
            : state_q == BUSY ? (cnt_q == '0 ? RESP : BUSY) : IDLE;
    cnt_d   = accept ? CNT_INIT
            : (state_q == BUSY && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_wr;
      end
      if (commit) begin
        rdata_q <= (c_wr || c_err) ? 64'd0 : mem[c_idx];
        err_q   <= c_err;
      end
    end
  end
  // Gated by rst so a reset landing on the commit edge drops the store
  always_ff @(posedge clk) begin
    if (rst && commit && c_wr && !c_err) mem[c_idx] <= c_wdata;
  end
  assign req_ready = rst && state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule
